// File: rtl/imem_loader_if.sv
// Byte-stream load port and instruction-RAM write port of the instruction memory loader.
// The slave modport is the loader; the master modport is the host/RAM side.
interface imem_loader_if #(
  parameter int SIZE = 64,
  parameter int LW   = $clog2(SIZE) + 1
);
  logic          start;
  logic [LW-1:0] len;
  logic          abort;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          mem_we;
  logic [31:0]   mem_adr;
  logic [31:0]   mem_wd;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          err;

  modport slave (
    input  start, len, abort, byte_in, byte_valid,
    output byte_ready, mem_we, mem_adr, mem_wd, busy, cpu_hold, done, err
  );

  modport master (
    output start, len, abort, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_adr, mem_wd, busy, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a program into instruction RAM from a byte stream, packing big-endian
// 32-bit words and holding the CPU in reset until the load completes.
module imem_loader #(
  parameter int SIZE = 64,
  parameter int LW   = $clog2(SIZE) + 1
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);
  localparam int IW = $clog2(SIZE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   asm_q, asm_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   wd_q, wd_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic len_ok;
  logic accept;
  logic last_word;

  assign len_ok    = (bus.len != '0) && (bus.len <= LW'(SIZE));
  assign accept    = (state_q == S_RECV) && bus.byte_valid && !bus.abort;
  assign last_word = (LW'(idx_q) == len_q - LW'(1));

  // NOTE: every next-state signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          done_d = 1'b0;
          if (!len_ok) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            len_d   = bus.len;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b0;
        end else if (accept) begin
          cnt_d = cnt_q + 2'd1;
          asm_d = {asm_q[15:0], bus.byte_in};
          // Output registers load on the 4th byte so they are stable for the whole write cycle.
          if (cnt_q == 2'd3) begin
            wd_d    = {asm_q, bus.byte_in};
            adr_d   = 32'({idx_q, 2'b00});
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b0;
        end else if (last_word) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      adr_q   <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Abort wins over a pending write and blocks byte acceptance in the same cycle.
  assign bus.byte_ready = (state_q == S_RECV) && !bus.abort;
  assign bus.mem_we     = (state_q == S_WRITE) && !bus.abort;
  assign bus.mem_adr    = adr_q;
  assign bus.mem_wd     = wd_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.cpu_hold   = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: normal loads, stalls, rejection,
// full-depth load, abort, asynchronous reset and start-while-busy.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] log_adr[$];
  logic [31:0] log_wd[$];

  imem_loader_if #(.SIZE(64)) bus();
  imem_loader #(.SIZE(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  // Record every write strobe mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      log_adr.push_back(bus.mem_adr);
      log_wd.push_back(bus.mem_wd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_adr.delete();
    log_wd.delete();
  endtask

  task automatic do_start(input logic [6:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: byte_ready=%b after %0d cycles, required 1", bus.byte_ready, n);
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready, bus.mem_we} !== 6'b0 ||
        bus.mem_adr !== 32'h0 || bus.mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: b/h/d/e/r/we=%b adr=%h wd=%h, required all 0",
               {bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready, bus.mem_we}, bus.mem_adr, bus.mem_wd);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_two_words();
    clear_log();
    do_start(7'd2);
    checks++;
    if ({bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready} !== 5'b11001) begin
      errors++;
      $display("FAIL two_words_start: busy/hold/done/err/ready=%b, required 11001",
               {bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready});
    end
    send_word(32'h8C010004);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_adr !== 32'h0 || bus.mem_wd !== 32'h8C010004 || bus.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL two_words_w0: we=%b adr=%h wd=%h ready=%b, required 1/00000000/8c010004/0",
               bus.mem_we, bus.mem_adr, bus.mem_wd, bus.byte_ready);
    end
    send_word(32'hAC020008);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_adr !== 32'h4 || bus.mem_wd !== 32'hAC020008 || bus.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL two_words_w1: we=%b adr=%h wd=%h hold=%b, required 1/00000004/ac020008/1",
               bus.mem_we, bus.mem_adr, bus.mem_wd, bus.cpu_hold);
    end
    tick();
    checks++;
    if ({bus.busy, bus.cpu_hold, bus.done, bus.err, bus.mem_we} !== 5'b00100 || bus.mem_adr !== 32'h4) begin
      errors++;
      $display("FAIL two_words_done: busy/hold/done/err/we=%b adr=%h, required 00100 adr 00000004",
               {bus.busy, bus.cpu_hold, bus.done, bus.err, bus.mem_we}, bus.mem_adr);
    end
    checks++;
    if (log_adr.size() !== 2 || log_wd[0] !== 32'h8C010004 || log_wd[1] !== 32'hAC020008) begin
      errors++;
      $display("FAIL two_words_log: writes=%0d, required 2 with 8c010004,ac020008", log_adr.size());
    end
  endtask

  task automatic test_stall();
    logic [6:0]  pat;
    logic [31:0] word;
    int k;
    pat  = 7'b1001101;
    word = 32'h12345678;
    k    = 0;
    clear_log();
    do_start(7'd1);
    for (int i = 0; i < 7; i++) begin
      bus.byte_valid = pat[6-i];
      bus.byte_in    = pat[6-i] ? word[31-8*k -: 8] : 8'hFF;
      if (pat[6-i]) k++;
      tick();
      if (i == 5) begin
        checks++;
        if (bus.mem_we !== 1'b0 || bus.byte_ready !== 1'b1) begin
          errors++;
          $display("FAIL stall_partial: we=%b ready=%b after 3 bytes, required 0/1", bus.mem_we, bus.byte_ready);
        end
      end
    end
    bus.byte_valid = 1'b0;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.byte_ready !== 1'b0 || bus.mem_adr !== 32'h0 || bus.mem_wd !== 32'h12345678) begin
      errors++;
      $display("FAIL stall_write: we=%b ready=%b adr=%h wd=%h, required 1/0/00000000/12345678",
               bus.mem_we, bus.byte_ready, bus.mem_adr, bus.mem_wd);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || log_adr.size() !== 1) begin
      errors++;
      $display("FAIL stall_done: done=%b busy=%b writes=%0d, required 1/0/1", bus.done, bus.busy, log_adr.size());
    end
  endtask

  task automatic test_reject();
    clear_log();
    do_start(7'd0);
    checks++;
    if ({bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready} !== 5'b00010) begin
      errors++;
      $display("FAIL reject_len0: busy/hold/done/err/ready=%b, required 00010",
               {bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready});
    end
    tick();
    do_start(7'd65);
    checks++;
    if ({bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready} !== 5'b00010) begin
      errors++;
      $display("FAIL reject_len65: busy/hold/done/err/ready=%b, required 00010",
               {bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready});
    end
    tick();
    checks++;
    if (log_adr.size() !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_nowrite: writes=%0d busy=%b, required 0/0", log_adr.size(), bus.busy);
    end
  endtask

  task automatic test_full_len();
    clear_log();
    do_start(7'd64);
    checks++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL full_accept: busy=%b err=%b, required 1/0", bus.busy, bus.err);
    end
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_adr !== 32'hFC || bus.mem_wd !== 32'hFCFDFEFF) begin
      errors++;
      $display("FAIL full_last: we=%b adr=%h wd=%h, required 1/000000fc/fcfdfeff",
               bus.mem_we, bus.mem_adr, bus.mem_wd);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || log_adr.size() !== 64 || log_adr[1] !== 32'h4 || log_wd[1] !== 32'h04050607) begin
      errors++;
      $display("FAIL full_done: done=%b writes=%0d, required 1 and 64 writes with word1=04050607",
               bus.done, log_adr.size());
    end
  endtask

  task automatic test_abort();
    clear_log();
    do_start(7'd3);
    send_word(32'h10111213);
    send_byte(8'h14);
    send_byte(8'h15);
    bus.abort = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_recv_cycle: we=%b ready=%b, required 0/0", bus.mem_we, bus.byte_ready);
    end
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.cpu_hold, bus.done, bus.err} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_idle: busy/hold/done/err=%b, required 0001", {bus.busy, bus.cpu_hold, bus.done, bus.err});
    end
    tick();
    tick();
    checks++;
    if (log_adr.size() !== 1 || log_adr[0] !== 32'h0 || log_wd[0] !== 32'h10111213) begin
      errors++;
      $display("FAIL abort_log: writes=%0d, required exactly 1 at 00000000 = 10111213", log_adr.size());
    end
    do_start(7'd1);
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: err=%b busy=%b, required 0/1", bus.err, bus.busy);
    end
    send_word(32'hDEADBEEF);
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || log_wd.size() !== 2 || log_wd[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL abort_reload: done=%b err=%b writes=%0d, required 1/0/2", bus.done, bus.err, log_wd.size());
    end
  endtask

  task automatic test_abort_write();
    clear_log();
    do_start(7'd2);
    send_word(32'hCAFEF00D);
    bus.abort = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_write_we: we=%b, required 0", bus.mem_we);
    end
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.err} !== 3'b001 || log_adr.size() !== 0) begin
      errors++;
      $display("FAIL abort_write_state: busy/done/err=%b writes=%0d, required 001 and 0",
               {bus.busy, bus.done, bus.err}, log_adr.size());
    end
  endtask

  task automatic test_async_reset();
    clear_log();
    do_start(7'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready, bus.mem_we} !== 6'b0 ||
        bus.mem_adr !== 32'h0 || bus.mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: b/h/d/e/r/we=%b adr=%h wd=%h, required all 0",
               {bus.busy, bus.cpu_hold, bus.done, bus.err, bus.byte_ready, bus.mem_we}, bus.mem_adr, bus.mem_wd);
    end
    tick();
    reset = 1'b0;
    tick();
    do_start(7'd1);
    send_word(32'h24080005);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_adr !== 32'h0 || bus.mem_wd !== 32'h24080005) begin
      errors++;
      $display("FAIL reset_reload: we=%b adr=%h wd=%h, required 1/00000000/24080005",
               bus.mem_we, bus.mem_adr, bus.mem_wd);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    clear_log();
    do_start(7'd2);
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    bus.start = 1'b1;
    bus.len   = 7'd5;
    send_byte(8'hA3);
    bus.start = 1'b0;
    bus.len   = 7'd0;
    send_word(32'hB0B1B2B3);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_adr !== 32'h4 || bus.mem_wd !== 32'hB0B1B2B3) begin
      errors++;
      $display("FAIL busy_start_w1: we=%b adr=%h wd=%h, required 1/00000004/b0b1b2b3",
               bus.mem_we, bus.mem_adr, bus.mem_wd);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || log_adr.size() !== 2 || log_wd[0] !== 32'hA0A1A2A3) begin
      errors++;
      $display("FAIL busy_start_done: done=%b busy=%b writes=%0d, required 1/0/2",
               bus.done, bus.busy, log_adr.size());
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.abort      = 1'b0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    #1;
    test_reset();
    test_two_words();
    test_stall();
    test_reject();
    test_full_len();
    test_abort();
    test_abort_write();
    test_async_reset();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
